lfsr_seq_checker: RTL

//  Downstream consumer of the 4-bit LFSR generator. Samples the LFSR output each valid cycle,

---
 rtl/lfsr_seq_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lfsr_seq_checker.sv
// PRBS checker for a Fibonacci-style LFSR stream: hunts for the sequence, locks after a run
// of correct predictions, then free-runs its own predictor and counts mismatches.
module lfsr_seq_checker #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter int               LOCK_CNT   = 4,
  parameter int               UNLOCK_CNT = 3,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic             zero_seen,
  output logic [CNT_W-1:0] err_count,
  output logic             dbg_state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  // Handshake: din is consumed on every rising edge where din_valid is high; there is no
  // backpressure. Outputs describe the most recently consumed word, one cycle later.

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic             have_q, have_d;
  logic [MW-1:0]    match_q, match_d;
  logic [UW-1:0]    miss_q, miss_d;
  logic             err_d, lost_d, zero_d;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      pred_q    <= '0;
      have_q    <= 1'b0;
      match_q   <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      zero_seen <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      have_q    <= have_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_pulse <= err_d;
      lock_lost <= lost_d;
      zero_seen <= zero_d;
      err_count <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    have_d  = have_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    lost_d  = 1'b0;
    zero_d  = 1'b0;
    cnt_d   = err_count;
    if (din_valid) begin
      zero_d = (din == '0);
      case (state_q)
        HUNT: begin
          // While hunting the predictor is reseeded from every sample.
          pred_d = nxt(din);
          have_d = 1'b1;
          if (have_q && (din == pred_q) && (din != '0)) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = MW'(LOCK_CNT);
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Once locked the predictor free-runs so a bad word cannot corrupt it.
          pred_d = nxt(pred_q);
          if ((din == pred_q) && (din != '0)) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_count != '1) cnt_d = err_count + 1'b1;
            if (miss_q == UW'(UNLOCK_CNT - 1)) begin
              state_d = HUNT;
              lost_d  = 1'b1;
              match_d = '0;
              have_d  = 1'b0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clr_count) cnt_d = '0;
  end

  assign locked    = (state_q == LOCKED);
  assign dbg_state = state_q;

endmodule
